// File: rtl/rgb_yuv_pkg.sv
// rgb_yuv_pkg: BT.601 studio-range coefficients, accumulator init values and FSM states
package rgb_yuv_pkg;
  localparam logic signed [31:0] CY_R = 32'sd16843;
  localparam logic signed [31:0] CY_G = 32'sd33030;
  localparam logic signed [31:0] CY_B = 32'sd6423;
  localparam logic signed [31:0] CU_R = -32'sd9699;
  localparam logic signed [31:0] CU_G = -32'sd19071;
  localparam logic signed [31:0] CU_B = 32'sd28770;
  localparam logic signed [31:0] CV_R = 32'sd28770;
  localparam logic signed [31:0] CV_G = -32'sd24117;
  localparam logic signed [31:0] CV_B = -32'sd4653;
  localparam logic signed [31:0] ROUND = 32'sd32768;
  localparam logic signed [31:0] Y_INIT = (32'sd16 <<< 16) + ROUND;
  localparam logic signed [31:0] UV_INIT = (32'sd128 <<< 16) + ROUND;
  typedef enum logic [2:0] {IDLE, MUL_R, MUL_G, MUL_B, OUT} state_t;
endpackage

// File: rtl/rgb_yuv_clip.sv
// rgb_yuv_clip: clamp a signed 16.16 accumulator to an unsigned 8-bit pixel
module rgb_yuv_clip (
  input  logic signed [31:0] acc,
  output logic [7:0]         pix
);
  logic unused_frac;
  assign unused_frac = ^acc[15:0];
  assign pix = acc[31] ? 8'd0 : |acc[30:24] ? 8'd255 : acc[23:16];
endmodule

// File: rtl/rgb_yuv_encoder.sv
// rgb_yuv_encoder: RGB to BT.601 YUV, three shared multipliers sequenced over R/G/B, optional 4:2:2
module rgb_yuv_encoder
  import rgb_yuv_pkg::*;
#(
  parameter bit CHROMA_422 = 1'b1
) (
  input  logic       CLOCK_50_I,
  input  logic       resetn,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_R,
  input  logic [7:0] in_G,
  input  logic [7:0] in_B,
  input  logic       in_sol,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_Y,
  output logic [7:0] out_U,
  output logic [7:0] out_V,
  output logic       out_uv_valid
);
  state_t state;
  logic [7:0] r, g, b, y_c, u_c, v_c, u_e, v_e, avg_u, avg_v;
  logic sol_l, parity, pix_odd, odd, accept;
  logic signed [31:0] acc_y, acc_u, acc_v, px, cy, cu, cv, sum_y, sum_u, sum_v;
  assign in_ready = state == IDLE || (state == OUT && out_ready);
  assign accept = in_valid && in_ready;
  // one channel per cycle feeds all three accumulators
  always_comb begin
    px = state == MUL_R ? signed'({24'd0, r}) : state == MUL_G ? signed'({24'd0, g}) : signed'({24'd0, b});
    cy = state == MUL_R ? CY_R : state == MUL_G ? CY_G : CY_B;
    cu = state == MUL_R ? CU_R : state == MUL_G ? CU_G : CU_B;
    cv = state == MUL_R ? CV_R : state == MUL_G ? CV_G : CV_B;
    sum_y = (state == MUL_R ? Y_INIT : acc_y) + cy * px;
    sum_u = (state == MUL_R ? UV_INIT : acc_u) + cu * px;
    sum_v = (state == MUL_R ? UV_INIT : acc_v) + cv * px;
  end
  rgb_yuv_clip clip_y (.acc(sum_y), .pix(y_c));
  rgb_yuv_clip clip_u (.acc(sum_u), .pix(u_c));
  rgb_yuv_clip clip_v (.acc(sum_v), .pix(v_c));
  assign odd = CHROMA_422 && !sol_l && parity;
  assign avg_u = 8'((u_e + u_c + 9'd1) >> 1);
  assign avg_v = 8'((v_e + v_c + 9'd1) >> 1);
  always_ff @(posedge CLOCK_50_I or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      {r, g, b, sol_l} <= '0;
      {acc_y, acc_u, acc_v} <= '0;
      {u_e, v_e, parity, pix_odd} <= '0;
      {out_valid, out_uv_valid, out_Y, out_U, out_V} <= '0;
    end else begin
      if (accept) begin
        r <= in_R;
        g <= in_G;
        b <= in_B;
        sol_l <= in_sol;
      end
      case (state)
        IDLE: state <= accept ? MUL_R : IDLE;
        MUL_R, MUL_G: begin
          acc_y <= sum_y;
          acc_u <= sum_u;
          acc_v <= sum_v;
          state <= state == MUL_R ? MUL_G : MUL_B;
        end
        MUL_B: begin
          out_Y <= y_c;
          out_U <= odd ? avg_u : u_c;
          out_V <= odd ? avg_v : v_c;
          out_uv_valid <= !CHROMA_422 || odd;
          out_valid <= 1'b1;
          pix_odd <= odd;
          if (CHROMA_422 && !odd) begin
            u_e <= u_c;
            v_e <= v_c;
          end
          state <= OUT;
        end
        OUT: if (out_ready) begin
          out_valid <= 1'b0;
          out_uv_valid <= 1'b0;
          parity <= !pix_odd;
          state <= accept ? MUL_R : IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_rgb_yuv_encoder.sv
// tb_rgb_yuv_encoder: directed vectors for 4:2:2 and 4:4:4 instances, backpressure and mid-pixel reset
module tb_rgb_yuv_encoder;
  logic clk = 1'b0, resetn = 1'b0, in_valid = 1'b0, in_sol = 1'b0, out_ready = 1'b1;
  logic [7:0] in_R = '0, in_G = '0, in_B = '0;
  logic in_ready, out_valid, out_uv_valid, in_ready2, out_valid2, out_uv_valid2;
  logic [7:0] out_Y, out_U, out_V, out_Y2, out_U2, out_V2;
  int checks = 0, errors = 0;
  always #10 clk = ~clk;

  rgb_yuv_encoder dut (
    .CLOCK_50_I(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
    .in_R(in_R), .in_G(in_G), .in_B(in_B), .in_sol(in_sol), .out_valid(out_valid),
    .out_ready(out_ready), .out_Y(out_Y), .out_U(out_U), .out_V(out_V), .out_uv_valid(out_uv_valid)
  );
  rgb_yuv_encoder #(.CHROMA_422(1'b0)) dut444 (
    .CLOCK_50_I(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready2),
    .in_R(in_R), .in_G(in_G), .in_B(in_B), .in_sol(in_sol), .out_valid(out_valid2),
    .out_ready(out_ready), .out_Y(out_Y2), .out_U(out_U2), .out_V(out_V2), .out_uv_valid(out_uv_valid2)
  );

  typedef struct {
    logic [7:0] r, g, b;
    logic       sol;
    logic [7:0] y, u, v;
    logic       uvv;
    logic [7:0] ru, rv;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b, input logic sol);
    @(negedge clk);
    in_valid = 1'b1; in_R = r; in_G = g; in_B = b; in_sol = sol;
    for (int i = 0; i < 40 && !in_ready; i++) @(negedge clk);
    if (!in_ready) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_sol = 1'b0;
    in_R = 8'($urandom); in_G = 8'($urandom); in_B = 8'($urandom);
  endtask

  task automatic check_pixel(input string name, input vec_t v);
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk({name, "_early_valid"}, 32'(out_valid), 32'd0);
    @(posedge clk); @(negedge clk);
    chk({name, "_valid"}, 32'(out_valid), 32'd1);
    chk({name, "_Y"}, 32'(out_Y), 32'(v.y));
    chk({name, "_U"}, 32'(out_U), 32'(v.u));
    chk({name, "_V"}, 32'(out_V), 32'(v.v));
    chk({name, "_uvv"}, 32'(out_uv_valid), 32'(v.uvv));
    chk({name, "_444_Y"}, 32'(out_Y2), 32'(v.y));
    chk({name, "_444_U"}, 32'(out_U2), 32'(v.ru));
    chk({name, "_444_V"}, 32'(out_V2), 32'(v.rv));
    chk({name, "_444_uvv"}, 32'(out_uv_valid2), 32'd1);
  endtask

  initial begin
    tbl[0] = '{8'd0,   8'd0,   8'd0,   1'b1, 8'd16,  8'd128, 8'd128, 1'b0, 8'd128, 8'd128};
    tbl[1] = '{8'd255, 8'd0,   8'd0,   1'b0, 8'd82,  8'd109, 8'd184, 1'b1, 8'd90,  8'd240};
    tbl[2] = '{8'd255, 8'd255, 8'd255, 1'b0, 8'd235, 8'd128, 8'd128, 1'b0, 8'd128, 8'd128};
    tbl[3] = '{8'd255, 8'd0,   8'd0,   1'b0, 8'd82,  8'd109, 8'd184, 1'b1, 8'd90,  8'd240};
    tbl[4] = '{8'd255, 8'd0,   8'd0,   1'b1, 8'd82,  8'd90,  8'd240, 1'b0, 8'd90,  8'd240};
    tbl[5] = '{8'd0,   8'd0,   8'd0,   1'b1, 8'd16,  8'd128, 8'd128, 1'b0, 8'd128, 8'd128};
    tbl[6] = '{8'd255, 8'd255, 8'd255, 1'b0, 8'd235, 8'd128, 8'd128, 1'b1, 8'd128, 8'd128};
    tbl[7] = '{8'd0,   8'd0,   8'd255, 1'b0, 8'd41,  8'd240, 8'd110, 1'b0, 8'd240, 8'd110};
    tbl[8] = '{8'd0,   8'd255, 8'd0,   1'b0, 8'd145, 8'd147, 8'd72,  1'b1, 8'd54,  8'd34};
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_Y", 32'(out_Y), 32'd0);
    chk("rst_uvv", 32'(out_uv_valid), 32'd0);
    resetn = 1'b1;
    for (int i = 0; i < 9; i++) begin
      send(tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].sol);
      check_pixel($sformatf("vec%0d", i), tbl[i]);
    end
    // hold red in OUT for 10 cycles while white waits at the input
    @(negedge clk); out_ready = 1'b0;
    send(8'd255, 8'd0, 8'd0, 1'b1);
    check_pixel("bp_red", '{8'd255, 8'd0, 8'd0, 1'b1, 8'd82, 8'd90, 8'd240, 1'b0, 8'd90, 8'd240});
    in_valid = 1'b1; in_R = 8'd255; in_G = 8'd255; in_B = 8'd255;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_Y", 32'(out_Y), 32'd82);
      chk("bp_U", 32'(out_U), 32'd90);
      chk("bp_V", 32'(out_V), 32'd240);
    end
    out_ready = 1'b1; #1;
    chk("bp_release_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; in_R = 8'd7; in_G = 8'd99; in_B = 8'd3;
    check_pixel("bp_white", '{8'd255, 8'd255, 8'd255, 1'b0, 8'd235, 8'd109, 8'd184, 1'b1, 8'd128, 8'd128});
    send(8'd0, 8'd0, 8'd255, 1'b0);
    check_pixel("pre_rst_blue", tbl[7]);
    // reset lands while the next (odd) pixel is in MUL_G
    send(8'd255, 8'd0, 8'd0, 1'b0);
    @(posedge clk); #3;
    resetn = 1'b0; #2;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_Y", 32'(out_Y), 32'd0);
    chk("mid_rst_out_U", 32'(out_U), 32'd0);
    chk("mid_rst_out_V", 32'(out_V), 32'd0);
    chk("mid_rst_uvv", 32'(out_uv_valid), 32'd0);
    @(negedge clk); resetn = 1'b1;
    send(8'd255, 8'd0, 8'd0, 1'b0);
    check_pixel("post_rst_red", tbl[4]);
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
